matvec_sequencer: RTL and testbench
===================================

MATVEC_SEQUENCER -- requirements
Module: matvec_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of one matrix element.
REQ-002 SHALL have parameter ROWS, default 8, number of A rows, A FIFOs and MAC lanes.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0, word address of A row 0.
REQ-004 SHALL have parameter DRAIN_CYCLES, default 8, cycles waited after the last FIFO read.
REQ-005 Ports: clk  in  1  the only clock; all logic on its rising edge.
REQ-006 Ports: rst_n  in  1  asynchronous, active-low reset.
REQ-007 Ports: start  in  1  one-cycle request to run one matrix-vector pass.
REQ-008 Ports: busy  out  1  high in every state except IDLE.
REQ-009 Ports: done  out  1  one-cycle pulse when a pass completes.
REQ-010 Ports: clr  out  1  MAC accumulator clear pulse.
REQ-011 Ports: address  out  32  memory word address; read  out  1  read request.
REQ-012 Ports: readdata  in  64  memory data; readdatavalid  in  1  data valid; waitrequest  in  1  memory stall.
REQ-013 Ports: fifo_wdata  out  DATA_WIDTH  byte to the FIFO being written.
REQ-014 Ports: wrreq_a  out  ROWS  per-row A FIFO write enable; wrreq_b  out  1  B FIFO write enable.
REQ-015 Ports: wrfull_a  in  ROWS  A FIFO full flags; wrfull_b  in  1  B FIFO full flag.
REQ-016 Ports: rdreq_a  out  ROWS  A FIFO read and MAC lane enable; rdreq_b  out  1  B FIFO read enable.

Function
REQ-017 SHALL implement the FSM IDLE, CLEAR, REQ, WAIT, WRITE, CALC, DRAIN, DONE.
REQ-018 IDLE: start=1 -> CLEAR, word index w=0; start is ignored in every other state.
REQ-019 CLEAR: clr=1 for exactly this one cycle -> REQ.
REQ-020 REQ: read=1, address=BASE_ADDR+w, both held stable while waitrequest=1.
REQ-021 REQ: at the first cycle with read=1 and waitrequest=0 -> WAIT, read=0 next cycle.
REQ-022 WAIT: on readdatavalid=1, latch readdata -> WRITE, byte index b=0; readdatavalid in any other state is ignored.
REQ-023 WRITE: word w<ROWS targets A FIFO w; word w=ROWS targets the B FIFO.
REQ-024 WRITE: fifo_wdata=latched[8b+7:8b], byte 0 first; assert exactly one wrreq bit when the target is not full, then b++.
REQ-025 WRITE: when the target full flag is 1, drive wrreq low and hold b (stall; no byte dropped).
REQ-026 WRITE: after byte 7 -> REQ with w+1 if w<ROWS, else -> CALC with t=0 (ROWS+1 words total).
REQ-027 CALC: rdreq_b=(t<ROWS), rdreq_a[i]=(t>=i and t<i+ROWS); t counts 0..2*ROWS-2, then -> DRAIN.
REQ-028 DRAIN: wait DRAIN_CYCLES cycles with all rdreq low -> DONE.
REQ-029 DONE: done=1 for one cycle -> IDLE.
REQ-030 At most one wrreq bit SHALL be high in any cycle; wrreq and rdreq SHALL never be high in the same cycle.
REQ-031 address arithmetic SHALL be 32-bit modulo 2^32 (BASE_ADDR+w wraps).

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, w=0, b=0, t=0, and all outputs to 0 (address=0, fifo_wdata=0).
REQ-033 Reset mid-pass SHALL abandon the pass with no done pulse; FIFO flushing is external.

Verification
REQ-034 Nominal pass: zero-wait memory, latency 2, no full -> 9 reads at 0..8, 72 single-bit writes, rdreq_a[7] high t=7..14, done exactly 1 cycle.
REQ-035 waitrequest=1 for 3 cycles at w=4 -> address=4 and read=1 held 4 cycles, exactly one read accepted.
REQ-036 wrfull_a[2]=1 for 5 cycles during byte 3 of word 2 -> wrreq_a=0 for those cycles, byte 3 then written once, order preserved.
REQ-037 BASE_ADDR=32'hFFFF_FFFC -> addresses FFFFFFFC..FFFFFFFF, 0..4.
REQ-038 rst_n pulsed low during CALC at t=5 -> all outputs 0 same cycle, busy=0, no done; new start runs a full pass.
REQ-039 start held high throughout the pass -> ignored while busy; second pass begins only after the return to IDLE.

Source files
------------

// File: rtl/matvec_sequencer.sv
// rtl/matvec_sequencer.sv - matrix-vector pass sequencer: word fetch, FIFO fill, MAC lane schedule
module matvec_sequencer #(
    parameter int          DATA_WIDTH   = 8,
    parameter int          ROWS         = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int          DRAIN_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  clr,
    output logic [31:0]           address,
    output logic                  read,
    input  logic [63:0]           readdata,
    input  logic                  readdatavalid,
    input  logic                  waitrequest,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    output logic [ROWS-1:0]       wrreq_a,
    output logic                  wrreq_b,
    input  logic [ROWS-1:0]       wrfull_a,
    input  logic                  wrfull_b,
    output logic [ROWS-1:0]       rdreq_a,
    output logic                  rdreq_b
);
    localparam int ELEMS = 64 / DATA_WIDTH;
    localparam int BW    = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam int WW    = $clog2(ROWS + 1);
    localparam int TW    = $clog2(2 * ROWS);
    localparam int DW    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE, CLEAR, REQ, WAIT, WRITE, CALC, DRAIN, DONE
    } state_t;

    state_t                              state;
    logic [WW-1:0]                       w;
    logic [BW-1:0]                       b;
    logic [TW-1:0]                       t;
    logic [DW-1:0]                       dcnt;
    // Byte 0 goes straight to fifo_wdata on capture, so only the upper elements are kept.
    logic [ELEMS-2:0][DATA_WIDTH-1:0]    upper;
    logic [ROWS-1:0]                     wr_sel_a;
    logic                                wr_sel_b;
    logic                                tgt_full;

    function automatic logic [ROWS-1:0] row_onehot(input logic [WW-1:0] idx);
        row_onehot = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (idx == WW'(i)) row_onehot[i] = 1'b1;
        end
    endfunction

    // Lane i consumes its row during the diagonal window t = i .. i+ROWS-1.
    function automatic logic [ROWS-1:0] lane_mask(input logic [TW-1:0] tv);
        for (int i = 0; i < ROWS; i++) begin
            lane_mask[i] = (int'(tv) >= i) && (int'(tv) < i + ROWS);
        end
    endfunction

    // The selected target is registered; the full flag gates the strobe in the same cycle
    // so a full FIFO never sees a write and the byte index simply holds.
    assign tgt_full = (|(wr_sel_a & wrfull_a)) | (wr_sel_b & wrfull_b);
    assign wrreq_a  = wr_sel_a & ~wrfull_a;
    assign wrreq_b  = wr_sel_b & ~wrfull_b;

    // Pass sequencer: every output register is loaded on the transition into its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            w          <= '0;
            b          <= '0;
            t          <= '0;
            dcnt       <= '0;
            upper      <= '0;
            wr_sel_a   <= '0;
            wr_sel_b   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            clr        <= 1'b0;
            address    <= '0;
            read       <= 1'b0;
            fifo_wdata <= '0;
            rdreq_a    <= '0;
            rdreq_b    <= 1'b0;
        end else begin
            clr  <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CLEAR;
                        w     <= '0;
                        b     <= '0;
                        t     <= '0;
                        busy  <= 1'b1;
                        clr   <= 1'b1;
                    end
                end
                CLEAR: begin
                    state   <= REQ;
                    read    <= 1'b1;
                    address <= BASE_ADDR + 32'(w);
                end
                REQ: begin
                    if (!waitrequest) begin
                        state <= WAIT;
                        read  <= 1'b0;
                    end
                end
                WAIT: begin
                    if (readdatavalid) begin
                        state      <= WRITE;
                        upper      <= readdata[63:DATA_WIDTH];
                        fifo_wdata <= readdata[DATA_WIDTH-1:0];
                        b          <= '0;
                        if (w == WW'(ROWS)) wr_sel_b <= 1'b1;
                        else                wr_sel_a <= row_onehot(w);
                    end
                end
                WRITE: begin
                    if (!tgt_full) begin
                        if (b == BW'(ELEMS - 1)) begin
                            wr_sel_a <= '0;
                            wr_sel_b <= 1'b0;
                            b        <= '0;
                            if (w == WW'(ROWS)) begin
                                state   <= CALC;
                                t       <= '0;
                                rdreq_b <= 1'b1;
                                rdreq_a <= lane_mask('0);
                            end else begin
                                state   <= REQ;
                                w       <= w + 1'b1;
                                read    <= 1'b1;
                                address <= BASE_ADDR + 32'(w) + 32'd1;
                            end
                        end else begin
                            b          <= b + 1'b1;
                            fifo_wdata <= upper[b];
                        end
                    end
                end
                CALC: begin
                    if (t == TW'(2 * ROWS - 2)) begin
                        state   <= DRAIN;
                        rdreq_a <= '0;
                        rdreq_b <= 1'b0;
                        dcnt    <= '0;
                    end else begin
                        t       <= t + 1'b1;
                        rdreq_b <= (int'(t) + 1 < ROWS);
                        rdreq_a <= lane_mask(t + 1'b1);
                    end
                end
                DRAIN: begin
                    if (dcnt == DW'(DRAIN_CYCLES - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matvec_sequencer.sv
// tb/tb_matvec_sequencer.sv - randomized self-checking bench for matvec_sequencer
module tb_matvec_sequencer;
    localparam int          ROWS  = 8;
    localparam int          DRAIN = 8;
    localparam logic [31:0] TB_BASE = 32'hFFFF_FFFC;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            busy, done, clr, read;
    logic [31:0]     address;
    logic [63:0]     readdata;
    logic            readdatavalid, waitrequest;
    logic [7:0]      fifo_wdata;
    logic [ROWS-1:0] wrreq_a, wrfull_a, rdreq_a;
    logic            wrreq_b, wrfull_b, rdreq_b;

    matvec_sequencer #(
        .DATA_WIDTH(8), .ROWS(ROWS), .BASE_ADDR(TB_BASE), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .clr(clr),
        .address(address), .read(read), .readdata(readdata), .readdatavalid(readdatavalid),
        .waitrequest(waitrequest), .fifo_wdata(fifo_wdata), .wrreq_a(wrreq_a), .wrreq_b(wrreq_b),
        .wrfull_a(wrfull_a), .wrfull_b(wrfull_b), .rdreq_a(rdreq_a), .rdreq_b(rdreq_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] mem [ROWS+1];
    logic [7:0]  exp_a [ROWS][$];
    logic [7:0]  exp_b [$];

    int cyc = 0;
    int nreads, start_cyc, clr_cnt, clr_cyc, first_b, cnt_b, last_rd, done_cnt, done_cyc;
    int first_a [ROWS];
    int last_a  [ROWS];
    int cnt_a   [ROWS];
    bit prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;

    int cfg_lat = 2, cfg_maxwait = 0, cfg_full_pct = 0, cfg_stall_word = -1;
    int pend = 0, pend_idx = 0, wait_left = -1;
    bit ff_armed = 1'b0;
    int ff_left = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},  64'(busy), 64'd0);
        check({tag, "_done"},  64'(done), 64'd0);
        check({tag, "_clr"},   64'(clr), 64'd0);
        check({tag, "_read"},  64'(read), 64'd0);
        check({tag, "_addr"},  64'(address), 64'd0);
        check({tag, "_wdata"}, 64'(fifo_wdata), 64'd0);
        check({tag, "_wr"},    64'({wrreq_b, wrreq_a}), 64'd0);
        check({tag, "_rd"},    64'({rdreq_b, rdreq_a}), 64'd0);
    endtask

    task automatic prepare_pass();
        for (int i = 0; i < ROWS; i++) exp_a[i].delete();
        exp_b.delete();
        for (int wi = 0; wi <= ROWS; wi++) begin
            mem[wi] = {$urandom, $urandom};
            for (int j = 0; j < 8; j++) begin
                if (wi < ROWS) exp_a[wi].push_back(mem[wi][8*j +: 8]);
                else           exp_b.push_back(mem[wi][8*j +: 8]);
            end
        end
        nreads = 0; start_cyc = -1; clr_cnt = 0; clr_cyc = -1; first_b = -1; cnt_b = 0;
        last_rd = -1; done_cnt = 0; done_cyc = -1;
        for (int i = 0; i < ROWS; i++) begin
            first_a[i] = -1; last_a[i] = -1; cnt_a[i] = 0;
        end
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (done_cnt == 0 && k < 3000) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("done_seen", 64'(done_cnt != 0), 64'd1);
    endtask

    task automatic check_pass();
        check("reads", 64'(nreads), 64'(ROWS + 1));
        for (int i = 0; i < ROWS; i++) check("a_left", 64'(exp_a[i].size()), 64'd0);
        check("b_left", 64'(exp_b.size()), 64'd0);
        check("clr_cnt", 64'(clr_cnt), 64'd1);
        check("clr_after_start", 64'(clr_cyc), 64'(start_cyc + 1));
        check("b_cnt", 64'(cnt_b), 64'(ROWS));
        for (int i = 0; i < ROWS; i++) begin
            check("lane_first", 64'(first_a[i]), 64'(first_b + i));
            check("lane_len", 64'(last_a[i] - first_a[i] + 1), 64'(ROWS));
            check("lane_cnt", 64'(cnt_a[i]), 64'(ROWS));
        end
        check("drain_len", 64'(done_cyc), 64'(last_rd + DRAIN + 1));
        check("done_cnt", 64'(done_cnt), 64'd1);
        check("busy_idle", 64'(busy), 64'd0);
    endtask

    task automatic run_pass();
        prepare_pass();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        check_pass();
        repeat (4) @(posedge clk);
        #1;
        check("done_once", 64'(done_cnt), 64'd1);
    endtask

    // Memory and FIFO-full responder: inputs change 1 time unit after each rising edge.
    initial begin
        waitrequest = 1'b0; readdatavalid = 1'b0; readdata = '0; wrfull_a = '0; wrfull_b = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            readdatavalid = 1'b0;
            readdata = {$urandom, $urandom};
            for (int i = 0; i < ROWS; i++) wrfull_a[i] = (int'($urandom_range(0, 99)) < cfg_full_pct);
            wrfull_b = (int'($urandom_range(0, 99)) < cfg_full_pct);
            if (ff_armed && exp_a[2].size() == 5) begin
                ff_armed = 1'b0;
                ff_left = 5;
            end
            if (ff_left > 0) begin
                wrfull_a[2] = 1'b1;
                ff_left--;
            end
            if (!rst_n) begin
                pend = 0; wait_left = -1; waitrequest = 1'b0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        readdatavalid = 1'b1;
                        if (pend_idx >= 0 && pend_idx <= ROWS) readdata = mem[pend_idx];
                    end
                end else if ($urandom_range(0, 9) == 0) begin
                    readdatavalid = 1'b1;
                end
                if (read) begin
                    if (wait_left < 0)
                        wait_left = (int'(address - TB_BASE) == cfg_stall_word) ? 3
                                    : int'($urandom_range(0, cfg_maxwait));
                    if (wait_left > 0) begin
                        waitrequest = 1'b1;
                        wait_left--;
                    end else begin
                        waitrequest = 1'b0;
                        wait_left = -1;
                        pend = cfg_lat;
                        pend_idx = int'(address - TB_BASE);
                    end
                end else begin
                    waitrequest = ($urandom_range(0, 3) == 0);
                end
            end
        end
    end

    // Mid-cycle monitor: per-cycle invariants, byte scoreboard and schedule bookkeeping.
    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            check("wr_onehot", 64'($countones({wrreq_b, wrreq_a}) <= 1), 64'd1);
            check("wr_rd_excl", 64'((|{wrreq_b, wrreq_a}) && (|{rdreq_b, rdreq_a})), 64'd0);
            check("wr_when_full", 64'({wrreq_b & wrfull_b, wrreq_a & wrfull_a}), 64'd0);
            for (int i = 0; i < ROWS; i++) begin
                if (wrreq_a[i]) begin
                    if (exp_a[i].size() > 0) check("a_byte", 64'(fifo_wdata), 64'(exp_a[i].pop_front()));
                    else                     check("a_extra", 64'd1, 64'd0);
                end
            end
            if (wrreq_b) begin
                if (exp_b.size() > 0) check("b_byte", 64'(fifo_wdata), 64'(exp_b.pop_front()));
                else                  check("b_extra", 64'd1, 64'd0);
            end
            if (prev_stall) begin
                check("stall_read", 64'(read), 64'd1);
                check("stall_addr", 64'(address), 64'(prev_addr));
            end
            prev_stall = read && waitrequest;
            prev_addr  = address;
            if (read && !waitrequest) begin
                check("rd_addr", 64'(address), 64'(32'(TB_BASE + 32'(nreads))));
                nreads++;
            end
            if (start && !busy && start_cyc < 0) start_cyc = cyc;
            if (clr) begin
                clr_cnt++;
                clr_cyc = cyc;
                check("busy_at_clr", 64'(busy), 64'd1);
            end
            if (rdreq_b) begin
                if (first_b < 0) first_b = cyc;
                cnt_b++;
            end
            for (int i = 0; i < ROWS; i++) begin
                if (rdreq_a[i]) begin
                    if (first_a[i] < 0) first_a[i] = cyc;
                    last_a[i] = cyc;
                    cnt_a[i]++;
                    last_rd = cyc;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_at_done", 64'(busy), 64'd1);
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        int k;
        rst_n = 1'b0;
        start = 1'b0;
        prepare_pass();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // nominal pass, then a stalled request at word 4, then a held-full FIFO at word 2 byte 3
        cfg_lat = 2; cfg_maxwait = 0; cfg_full_pct = 0; cfg_stall_word = -1;
        run_pass();
        cfg_stall_word = 4;
        run_pass();
        cfg_stall_word = -1;
        ff_armed = 1'b1;
        run_pass();
        check("full_stall_applied", 64'(ff_armed), 64'd0);

        for (int p = 0; p < 6; p++) begin
            cfg_lat = int'($urandom_range(1, 4));
            cfg_maxwait = 3;
            cfg_full_pct = 25;
            run_pass();
        end

        // start held high across a whole pass, then kept high into the next IDLE
        prepare_pass();
        start = 1'b1;
        wait_done();
        check("held_no_restart", 64'(clr_cnt), 64'd1);
        check_pass();
        prepare_pass();
        @(posedge clk); #1;
        check("held_restart_clr", 64'(clr), 64'd1);
        check("held_restart_busy", 64'(busy), 64'd1);
        start = 1'b0;
        wait_done();
        check_pass();

        // reset asserted during CALC at t=5
        prepare_pass();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (first_b < 0 && k < 3000) begin
            @(posedge clk);
            k++;
        end
        check("calc_reached", 64'(first_b >= 0), 64'd1);
        repeat (4) @(posedge clk);
        #3;
        check("abort_rdreq_a", 64'(rdreq_a), 64'(8'h3F));
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_idle", 64'(busy), 64'd0);

        cfg_lat = 1; cfg_maxwait = 2; cfg_full_pct = 20;
        run_pass();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
